prog_loader: RTL and testbench

- Byte-stream program loader: the writer side of the instruction-fetch path.
- Receives framed 14-bit instruction words over a valid/ready byte interface and writes them into the writable program memory that the CPU fetches from.
- Holds the CPU in reset until a frame has loaded cleanly.
- Sits between the host/debug byte link and the program-memory write port.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader.sv | 155 +++++++++++++++
 tb/tb_prog_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared FSM encoding and frame field constants for the byte-stream program loader.
package prog_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CNT_HI, ST_CNT_LO, ST_W_HI, ST_W_LO, ST_WRITE, ST_CSUM, ST_DONE, ST_ERR
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int BYTE_W      = 8;
  localparam int CNT_HI_BITS = 3;  // low CNT_HI bits that form N[10:8]
  localparam int HI_BITS     = 6;  // low HI bits that form word[13:8]

  function automatic logic accepts(state_e s);
    return s inside {ST_IDLE, ST_CNT_HI, ST_CNT_LO, ST_W_HI, ST_W_LO, ST_CSUM};
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing 14-bit words into program memory; holds the CPU until done.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 11,
  parameter int         DATA_W    = 14,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rearm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_cnt
);

  state_e                   state_q;
  logic                     wr_en_q, cpu_hold_q, done_q, error_q;
  logic [ADDR_W-1:0]        wr_addr_q, word_cnt_q, n_q;
  logic [DATA_W-1:0]        wr_data_q;
  logic [BYTE_W-1:0]        cnt_hi_q;
  logic [HI_BITS-1:0]       hi_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]        sum_q;
`endif

  logic              xfer;
  logic [ADDR_W-1:0] cnt_inc;

  assign in_ready = accepts(state_q);
  assign xfer     = in_valid & in_ready;
  assign cnt_inc  = word_cnt_q + 1'b1;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= ADDR_W'(BASE_ADDR);
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      word_cnt_q <= '0;
      n_q        <= '0;
      cnt_hi_q   <= '0;
      hi_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (xfer && in_data == SYNC_BYTE) begin
          state_q <= ST_CNT_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_q   <= '0;
`endif
        end
        ST_CNT_HI: if (xfer) begin
          cnt_hi_q <= in_data;
          state_q  <= ST_CNT_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_q    <= sum_q + in_data;
`endif
        end
        ST_CNT_LO: if (xfer) begin
          if (cnt_hi_q[BYTE_W-1:CNT_HI_BITS] != '0 || {cnt_hi_q[CNT_HI_BITS-1:0], in_data} == '0) begin
            state_q <= ST_ERR;
            error_q <= 1'b1;
          end else begin
            n_q     <= ADDR_W'({cnt_hi_q[CNT_HI_BITS-1:0], in_data});
            state_q <= ST_W_HI;
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_q <= sum_q + in_data;
`endif
        end
        ST_W_HI: if (xfer) begin
          if (in_data[BYTE_W-1:HI_BITS] != '0) begin
            state_q <= ST_ERR;
            error_q <= 1'b1;
          end else begin
            hi_q    <= in_data[HI_BITS-1:0];
            state_q <= ST_W_LO;
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_q <= sum_q + in_data;
`endif
        end
        ST_W_LO: if (xfer) begin
          // Write is registered here so wr_en lands exactly in the WRITE cycle.
          wr_en_q   <= 1'b1;
          wr_addr_q <= ADDR_W'(BASE_ADDR) + word_cnt_q;
          wr_data_q <= DATA_W'({hi_q, in_data});
          state_q   <= ST_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_q     <= sum_q + in_data;
`endif
        end
        ST_WRITE: begin
          word_cnt_q <= cnt_inc;
          if (cnt_inc == n_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_q    <= ST_CSUM;
`else
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
`endif
          end else begin
            state_q <= ST_W_HI;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM: if (xfer) begin
          if (BYTE_W'(sum_q + in_data) == '0) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q <= ST_ERR;
            error_q <= 1'b1;
          end
        end
`endif
        ST_DONE, ST_ERR: if (rearm) begin
          state_q    <= ST_IDLE;
          cpu_hold_q <= 1'b1;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
          word_cnt_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued by stimulus, popped by a write monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        rearm = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [13:0] wr_data;
  logic        cpu_hold, done, error;
  logic [10:0] word_cnt;

  prog_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rearm(rearm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [10:0] a; logic [13:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: DUT updates on negedge, so sample on posedge.
  always @(posedge clk) begin
    if (reset && wr_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {21'd0, wr_addr}, {21'd0, mon_e.a});
        chk("wr_data", {18'd0, wr_data}, {18'd0, mon_e.d});
      end
      chk("in_ready_in_write", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    if (gap) @(posedge clk);
    @(posedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %0h never accepted, expected in_ready", b);
    end
    @(negedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit add_cs, input bit gap);
    logic [7:0] s;
    s = 8'h00;
    foreach (bytes[i]) begin
      send(bytes[i], gap);
      if (i > 0) s = s + bytes[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (add_cs) send(8'h00 - s, gap);
`else
    if (add_cs && s == 8'h00) s = 8'h01;
`endif
  endtask

  task automatic status(input string tag, input logic d, input logic e, input logic h, input logic [10:0] wc);
    repeat (3) @(posedge clk);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    chk({tag, "_word_cnt"}, {21'd0, word_cnt}, {21'd0, wc});
    chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  task automatic do_rearm(input string tag);
    @(posedge clk);
    rearm = 1'b1;
    @(negedge clk);
    #1 rearm = 1'b0;
    @(posedge clk);
    chk({tag, "_rearm_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_rearm_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_rearm_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_rearm_cnt"}, {21'd0, word_cnt}, 32'd0);
    chk({tag, "_rearm_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, {21'd0, wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, {18'd0, wr_data}, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_word_cnt"}, {21'd0, word_cnt}, 32'd0);
  endtask

  logic [7:0] fr[$];

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("in_reset");
    @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    chk_reset_vals("after_reset");

    // Two-word frame
    fr = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h12, 8'h3E, 8'h05};
    exp_q.push_back('{11'd0, 14'h3012});
    exp_q.push_back('{11'd1, 14'h3E05});
    send_frame(fr, 1'b1, 1'b0);
    status("two_word", 1'b1, 1'b0, 1'b0, 11'd2);
    chk("done_ready", {31'd0, in_ready}, 32'd0);
    do_rearm("two_word");

    // Leading garbage is discarded
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h28, 8'h03};
    exp_q.push_back('{11'd0, 14'h2803});
    send(fr[0], 1'b0);
    send(fr[1], 1'b0);
    fr = fr[2:$];
    send_frame(fr, 1'b1, 1'b0);
    status("resync", 1'b1, 1'b0, 1'b0, 11'd1);
    do_rearm("resync");

    // Zero count is rejected
    fr = '{8'hA5, 8'h00, 8'h00};
    send_frame(fr, 1'b0, 1'b0);
    status("zero_cnt", 1'b0, 1'b1, 1'b1, 11'd0);
    chk("err_ready", {31'd0, in_ready}, 32'd0);
    do_rearm("zero_cnt");

    // Nonzero CNT_HI[7:3] is rejected
    fr = '{8'hA5, 8'h08, 8'h01};
    send_frame(fr, 1'b0, 1'b0);
    status("bad_cnt_hi", 1'b0, 1'b1, 1'b1, 11'd0);
    do_rearm("bad_cnt_hi");

    // Bad HI on second word: first write stays
    fr = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h12, 8'hC0};
    exp_q.push_back('{11'd0, 14'h3012});
    send_frame(fr, 1'b0, 1'b0);
    status("bad_hi", 1'b0, 1'b1, 1'b1, 11'd1);
    do_rearm("bad_hi");

    // Three words with in_valid toggling
    fr = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h3F, 8'hFF, 8'h00, 8'h00};
    exp_q.push_back('{11'd0, 14'h0102});
    exp_q.push_back('{11'd1, 14'h3FFF});
    exp_q.push_back('{11'd2, 14'h0000});
    send_frame(fr, 1'b1, 1'b1);
    status("toggle", 1'b1, 1'b0, 1'b0, 11'd3);
    do_rearm("toggle");

`ifdef PROG_LOADER_CHECKSUM_EN
    // Wrong checksum byte
    fr = '{8'hA5, 8'h00, 8'h01, 8'h30, 8'h12, 8'h00};
    exp_q.push_back('{11'd0, 14'h3012});
    send_frame(fr, 1'b0, 1'b0);
    status("bad_csum", 1'b0, 1'b1, 1'b1, 11'd1);
    do_rearm("bad_csum");
`endif

    // Reset mid-frame, with a word pending in W_LO
    fr = '{8'hA5, 8'h00, 8'h02, 8'h30};
    send_frame(fr, 1'b0, 1'b0);
    @(posedge clk);
    reset = 1'b0;
    #1 chk_reset_vals("mid_reset");
    repeat (2) @(posedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    chk_reset_vals("post_mid_reset");

    // Loader still works after the abort
    fr = '{8'hA5, 8'h00, 8'h01, 8'h15, 8'hAA};
    exp_q.push_back('{11'd0, 14'h15AA});
    send_frame(fr, 1'b1, 1'b0);
    status("after_abort", 1'b1, 1'b0, 1'b0, 11'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
